// File: rtl/pc_sequencer_pkg.sv
// Opcode encodings shared by the PC sequencer and its users.
// Values 6 and 7 are unassigned and decode as hold.
package pc_defs;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_INC    = 3'd1,
    PC_JUMP   = 3'd2,
    PC_BRANCH = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bus: the master issues ops, the sequencer (slave) returns pc and RAS status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic [2:0]        op;
  logic [ADDR_W-1:0] new_adr;
  logic [ADDR_W-1:0] imm;
  logic [ADDR_W-1:0] pc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_fault;

  modport master (
    output stall, op, new_adr, imm,
    input  pc, ras_empty, ras_full, ras_fault
  );

  modport slave (
    input  stall, op, new_adr, imm,
    output pc, ras_empty, ras_full, ras_fault
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: LIFO array plus occupancy count. Pushes are ignored when full,
// pops when empty; array contents are never reset, only the count.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] count_reg;
  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  // When full the low count bits wrap to 0, so top_idx still lands on the last entry.
  assign wr_idx  = count_reg[IDX_W-1:0];
  assign top_idx = wr_idx - IDX_W'(1);
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: inc / jump / relative branch / call-return with a RAS.
// Optional build macro PC_TRAP_EN redirects pc to TRAP_VEC on any RAS fault.
module pc_sequencer
  import pc_defs::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 16'h0000,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 16'h00F0
) (
  input logic             clk,
  input logic             reset,
  pc_sequencer_if.slave   bus
);
`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc, ras_dout;
  logic              fault_reg, fault_next;
  logic              push, pop, ras_empty, ras_full;

  assign pc_inc = pc_reg + ADDR_W'(1);

  always_comb begin
    pc_next    = pc_reg;
    fault_next = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (!bus.stall) begin
      case (bus.op)
        PC_INC:    pc_next = pc_inc;
        PC_JUMP:   pc_next = bus.new_adr;
        PC_BRANCH: pc_next = pc_reg + bus.imm;
        PC_CALL: begin
          // The jump is taken even if the return address cannot be saved.
          pc_next = bus.new_adr;
          if (ras_full) fault_next = 1'b1;
          else          push       = 1'b1;
        end
        PC_RET: begin
          if (ras_empty) begin
            pc_next    = pc_inc;
            fault_next = 1'b1;
          end else begin
            pc_next = ras_dout;
            pop     = 1'b1;
          end
        end
        default: pc_next = pc_reg;
      endcase
      if (TRAP_EN && fault_next) pc_next = TRAP_VEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_VEC;
      fault_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign bus.pc        = pc_reg;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_fault = fault_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, inc/wrap, branch, call/return, RAS overflow/underflow, stall.
module tb_pc_sequencer;
  import pc_defs::*;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [15:0] TRAP_PC = 16'h00F0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(16)) bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cycle(input logic [2:0] op, input logic [15:0] adr, input logic [15:0] imm);
    bus.op      = op;
    bus.new_adr = adr;
    bus.imm     = imm;
    @(posedge clk);
    #1;
    $display("op=%0d adr=%h imm=%h stall=%b -> pc=%h empty=%b full=%b fault=%b",
             op, adr, imm, bus.stall, bus.pc, bus.ras_empty, bus.ras_full, bus.ras_fault);
  endtask

  task automatic test_reset;
    cycle(PC_HOLD, 16'h0, 16'h0);
    checks++;
    if (bus.pc !== 16'h0000 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.ras_fault !== 1'b0)
      $display("FAIL reset_state: pc=%h empty=%b full=%b fault=%b, want 0000 1 0 0",
               bus.pc, bus.ras_empty, bus.ras_full, bus.ras_fault);
    else passed++;
    reset = 1'b0;
    cycle(PC_CALL, 16'h0050, 16'h0);
    cycle(PC_CALL, 16'h0123, 16'h0);
    checks++;
    if (bus.pc !== 16'h0123 || bus.ras_empty !== 1'b0)
      $display("FAIL reset_setup: pc=%h empty=%b, want 0123 0", bus.pc, bus.ras_empty);
    else passed++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 16'h0000 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0)
      $display("FAIL reset_async: pc=%h empty=%b full=%b, want 0000 1 0",
               bus.pc, bus.ras_empty, bus.ras_full);
    else passed++;
    #1 reset = 1'b0;
    // Stack must be gone: a RET now underflows.
    cycle(PC_RET, 16'h0, 16'h0);
    checks++;
    if (bus.ras_fault !== 1'b1 || bus.pc !== (TRAP ? TRAP_PC : 16'h0001))
      $display("FAIL reset_discard: pc=%h fault=%b, want %h 1",
               bus.pc, bus.ras_fault, TRAP ? TRAP_PC : 16'h0001);
    else passed++;
  endtask

  task automatic test_inc;
    logic [15:0] exp;
    cycle(PC_JUMP, 16'h0000, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle(PC_INC, 16'h0, 16'h0);
      exp = 16'(i);
      checks++;
      if (bus.pc !== exp) $display("FAIL inc_%0d: pc=%h want %h", i, bus.pc, exp);
      else passed++;
    end
    cycle(PC_JUMP, 16'hFFFF, 16'h0);
    cycle(PC_INC, 16'h0, 16'h0);
    checks++;
    if (bus.pc !== 16'h0000 || bus.ras_fault !== 1'b0)
      $display("FAIL inc_wrap: pc=%h fault=%b want 0000 0", bus.pc, bus.ras_fault);
    else passed++;
  endtask

  task automatic test_branch;
    cycle(PC_JUMP, 16'h0010, 16'h0);
    cycle(PC_BRANCH, 16'h0, 16'hFFFC);
    checks++;
    if (bus.pc !== 16'h000C) $display("FAIL branch_back: pc=%h want 000C", bus.pc);
    else passed++;
    cycle(PC_BRANCH, 16'h0, 16'h0005);
    checks++;
    if (bus.pc !== 16'h0011) $display("FAIL branch_fwd: pc=%h want 0011", bus.pc);
    else passed++;
    cycle(PC_JUMP, 16'hFFFE, 16'h0);
    cycle(PC_BRANCH, 16'h0, 16'h0003);
    checks++;
    if (bus.pc !== 16'h0001) $display("FAIL branch_wrap: pc=%h want 0001", bus.pc);
    else passed++;
  endtask

  task automatic test_call_ret;
    cycle(PC_JUMP, 16'h0020, 16'h0);
    cycle(PC_CALL, 16'h0100, 16'h0);
    checks++;
    if (bus.pc !== 16'h0100 || bus.ras_empty !== 1'b0)
      $display("FAIL call: pc=%h empty=%b want 0100 0", bus.pc, bus.ras_empty);
    else passed++;
    cycle(PC_RET, 16'h0, 16'h0);
    checks++;
    if (bus.pc !== 16'h0021 || bus.ras_empty !== 1'b1 || bus.ras_fault !== 1'b0)
      $display("FAIL ret: pc=%h empty=%b fault=%b want 0021 1 0", bus.pc, bus.ras_empty, bus.ras_fault);
    else passed++;
  endtask

  task automatic test_ras_limits;
    logic [15:0] ret_exp [4];
    ret_exp = '{16'h0501, 16'h0401, 16'h0301, 16'h0201};
    cycle(PC_JUMP, 16'h0200, 16'h0);
    for (int i = 0; i < 4; i++) cycle(PC_CALL, 16'h0300 + 16'(i) * 16'h0100, 16'h0);
    checks++;
    if (bus.pc !== 16'h0600 || bus.ras_full !== 1'b1 || bus.ras_fault !== 1'b0)
      $display("FAIL ras_fill: pc=%h full=%b fault=%b want 0600 1 0", bus.pc, bus.ras_full, bus.ras_fault);
    else passed++;
    cycle(PC_CALL, 16'h0700, 16'h0);
    checks++;
    if (bus.pc !== (TRAP ? TRAP_PC : 16'h0700) || bus.ras_fault !== 1'b1 || bus.ras_full !== 1'b1)
      $display("FAIL call_overflow: pc=%h fault=%b full=%b want %h 1 1",
               bus.pc, bus.ras_fault, bus.ras_full, TRAP ? TRAP_PC : 16'h0700);
    else passed++;
    cycle(PC_HOLD, 16'h0, 16'h0);
    checks++;
    if (bus.ras_fault !== 1'b0) $display("FAIL fault_pulse: fault=%b want 0", bus.ras_fault);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle(PC_RET, 16'h0, 16'h0);
      checks++;
      if (bus.pc !== ret_exp[i] || bus.ras_fault !== 1'b0)
        $display("FAIL ret_order_%0d: pc=%h fault=%b want %h 0", i, bus.pc, bus.ras_fault, ret_exp[i]);
      else passed++;
    end
    checks++;
    if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0)
      $display("FAIL ras_drain: empty=%b full=%b want 1 0", bus.ras_empty, bus.ras_full);
    else passed++;
    cycle(PC_RET, 16'h0, 16'h0);
    checks++;
    if (bus.pc !== (TRAP ? TRAP_PC : 16'h0202) || bus.ras_fault !== 1'b1 || bus.ras_empty !== 1'b1)
      $display("FAIL ret_underflow: pc=%h fault=%b empty=%b want %h 1 1",
               bus.pc, bus.ras_fault, bus.ras_empty, TRAP ? TRAP_PC : 16'h0202);
    else passed++;
  endtask

  task automatic test_stall;
    cycle(PC_JUMP, 16'h0040, 16'h0);
    bus.stall = 1'b1;
    cycle(PC_JUMP, 16'h0BAD, 16'h0);
    checks++;
    if (bus.pc !== 16'h0040) $display("FAIL stall_jump: pc=%h want 0040", bus.pc);
    else passed++;
    cycle(PC_CALL, 16'h0BAD, 16'h0);
    cycle(PC_RET, 16'h0, 16'h0);
    checks++;
    if (bus.pc !== 16'h0040 || bus.ras_empty !== 1'b1 || bus.ras_fault !== 1'b0)
      $display("FAIL stall_ras: pc=%h empty=%b fault=%b want 0040 1 0", bus.pc, bus.ras_empty, bus.ras_fault);
    else passed++;
    bus.stall = 1'b0;
    cycle(PC_JUMP, 16'h0BAD, 16'h0);
    checks++;
    if (bus.pc !== 16'h0BAD) $display("FAIL stall_release: pc=%h want 0BAD", bus.pc);
    else passed++;
  endtask

  task automatic test_hold_ops;
    cycle(3'd6, 16'h1234, 16'h0001);
    cycle(3'd7, 16'h1234, 16'h0001);
    cycle(PC_HOLD, 16'h1234, 16'h0001);
    checks++;
    if (bus.pc !== 16'h0BAD || bus.ras_empty !== 1'b1)
      $display("FAIL hold_ops: pc=%h empty=%b want 0BAD 1", bus.pc, bus.ras_empty);
    else passed++;
  endtask

  initial begin
    bus.stall   = 1'b0;
    bus.op      = PC_HOLD;
    bus.new_adr = '0;
    bus.imm     = '0;
    test_reset();
    test_inc();
    test_branch();
    test_call_ret();
    test_ras_limits();
    test_stall();
    test_hold_ops();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
